rplace_reseed_ctrl: RTL and testbench

//  Sequences safe re-keying of the randomized cache placement function. Counts

---
 rtl/rplace_reseed_ctrl_pkg.sv | 14 +
 rtl/rplace_reseed_ctrl.sv | 125 ++++++++++++
 tb/tb_rplace_reseed_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rplace_reseed_ctrl_pkg.sv
// Shared types and defaults for the randomized-placement reseed controller.
package rplace_reseed_ctrl_pkg;

   typedef enum logic [1:0] {
      RS_IDLE,
      RS_DRAIN,
      RS_FLUSH,
      RS_RESEED
   } rplace_state_t;

   localparam int EPOCH_BITS_DEFAULT = 16;
   localparam int PERF_BITS_DEFAULT  = 32;

endpackage

// File: rtl/rplace_reseed_ctrl.sv
// Re-keys the randomized cache placement: count, drain, flush, reseed.
// Define RPLACE_RESEED_PERF_EN to add the reseed_count event counter.
module rplace_reseed_ctrl
   import rplace_reseed_ctrl_pkg::*;
#(
   parameter int EPOCH_BITS = EPOCH_BITS_DEFAULT
`ifdef RPLACE_RESEED_PERF_EN
   ,
   parameter int PERF_BITS = PERF_BITS_DEFAULT
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  access_valid,
   input  logic [EPOCH_BITS-1:0] epoch_thresh,
   input  logic                  sw_reseed_req,
   input  logic                  miss_pending,
   output logic                  flush_req,
   input  logic                  flush_done,
   output logic                  stall_o,
   output logic                  reseed,
   output logic                  busy
`ifdef RPLACE_RESEED_PERF_EN
   ,
   output logic [PERF_BITS-1:0]  reseed_count
`endif
);

   localparam logic [EPOCH_BITS-1:0] ONE = {{(EPOCH_BITS-1){1'b0}}, 1'b1};

   rplace_state_t         state_q, state_d;
   logic [EPOCH_BITS-1:0] count_q, count_d;
   logic [EPOCH_BITS-1:0] thresh_m1;
   logic                  sw_pend_q, sw_pend_d;
   logic                  flush_req_q, flush_req_d;
   logic                  stall_q, stall_d;
   logic                  reseed_q, reseed_d;
   logic                  busy_q, busy_d;
   logic                  acc;
   logic                  auto_trig;
   logic                  trig;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RS_IDLE;
         count_q     <= '0;
         sw_pend_q   <= 1'b0;
         flush_req_q <= 1'b0;
         stall_q     <= 1'b0;
         reseed_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sw_pend_q   <= sw_pend_d;
         flush_req_q <= flush_req_d;
         stall_q     <= stall_d;
         reseed_q    <= reseed_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      sw_pend_d = sw_pend_q;
      // accesses issued against an active stall are a protocol error
      acc       = access_valid & ~stall_q;
      thresh_m1 = epoch_thresh - ONE;
      auto_trig = (epoch_thresh != '0) && acc && (count_q >= thresh_m1);
      trig      = auto_trig || sw_reseed_req || sw_pend_q;
      unique case (state_q)
         RS_IDLE: begin
            if (acc && (count_q != '1)) count_d = count_q + ONE;
            if (trig) begin
               state_d   = RS_DRAIN;
               sw_pend_d = 1'b0;
            end
         end
         RS_DRAIN: begin
            if (sw_reseed_req) sw_pend_d = 1'b1;
            if (!miss_pending) state_d = RS_FLUSH;
         end
         RS_FLUSH: begin
            if (sw_reseed_req) sw_pend_d = 1'b1;
            if (flush_done) state_d = RS_RESEED;
         end
         RS_RESEED: begin
            // a request seen here is covered by this seed change
            count_d = '0;
            state_d = RS_IDLE;
         end
         default: state_d = RS_IDLE;
      endcase
   end

   always_comb begin
      stall_d     = (state_d != RS_IDLE);
      busy_d      = (state_d != RS_IDLE);
      flush_req_d = (state_d == RS_FLUSH);
      reseed_d    = (state_d == RS_RESEED);
   end

   assign flush_req = flush_req_q;
   assign stall_o   = stall_q;
   assign reseed    = reseed_q;
   assign busy      = busy_q;

`ifdef RPLACE_RESEED_PERF_EN
   logic [PERF_BITS-1:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (reseed_q) perf_d = perf_q + {{(PERF_BITS-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign reseed_count = perf_q;
`endif

endmodule

// File: tb/tb_rplace_reseed_ctrl.sv
// Self-checking bench for rplace_reseed_ctrl: vector table plus
// hand-written multi-cycle sequences.
module tb_rplace_reseed_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        access_valid;
   logic [15:0] epoch_thresh;
   logic        sw_reseed_req;
   logic        miss_pending;
   logic        flush_req;
   logic        flush_done;
   logic        stall_o;
   logic        reseed;
   logic        busy;
`ifdef RPLACE_RESEED_PERF_EN
   logic [31:0] reseed_count;
   logic [1:0]  rc2;
   logic        fr2, st2, rs2, bz2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rplace_reseed_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .access_valid (access_valid),
      .epoch_thresh (epoch_thresh),
      .sw_reseed_req(sw_reseed_req),
      .miss_pending (miss_pending),
      .flush_req    (flush_req),
      .flush_done   (flush_done),
      .stall_o      (stall_o),
      .reseed       (reseed),
      .busy         (busy)
`ifdef RPLACE_RESEED_PERF_EN
      ,
      .reseed_count (reseed_count)
`endif
   );

`ifdef RPLACE_RESEED_PERF_EN
   rplace_reseed_ctrl #(.PERF_BITS(2)) dut2 (
      .clk          (clk),
      .reset        (reset),
      .access_valid (access_valid),
      .epoch_thresh (epoch_thresh),
      .sw_reseed_req(sw_reseed_req),
      .miss_pending (miss_pending),
      .flush_req    (fr2),
      .flush_done   (flush_done),
      .stall_o      (st2),
      .reseed       (rs2),
      .busy         (bz2),
      .reseed_count (rc2)
   );
`endif

   // exp = {stall_o, busy, flush_req, reseed} after the edge
   typedef struct packed {
      logic       av;
      logic       sw;
      logic       mp;
      logic       fd;
      logic [3:0] exp;
   } vec_t;

   vec_t       vt [19];
   logic [3:0] sb_q [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {stall_o, busy, flush_req, reseed};
   endfunction

   task automatic quiet();
      access_valid  = 1'b0;
      sw_reseed_req = 1'b0;
      miss_pending  = 1'b0;
      flush_done    = 1'b0;
   endtask

   // cache model that acknowledges a flush one cycle after it is requested
   task automatic run_cycles(input int n, output int p);
      p = 0;
      for (int i = 0; i < n; i++) begin
         access_valid  = 1'b0;
         sw_reseed_req = 1'b0;
         miss_pending  = 1'b0;
         flush_done    = flush_req;
         step();
         if (reseed) p++;
      end
      flush_done = 1'b0;
   endtask

   task automatic sw_pulse();
      sw_reseed_req = 1'b1;
      step();
      sw_reseed_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int cnt;
      logic [3:0] e;
      logic seen;

      vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1101};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
      vt[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1100};
      vt[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1110};
      vt[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1101};
      vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};

      reset        = 1'b1;
      epoch_thresh = 16'd4;
      quiet();
      #1;
      chk("reset_outs", outs(), 4'b0000);
      step();
      step();
      reset = 1'b0;

      // epoch of 4 accesses, then a second epoch proving the count restarted
      for (int i = 0; i < 19; i++) begin
         access_valid  = vt[i].av;
         sw_reseed_req = vt[i].sw;
         miss_pending  = vt[i].mp;
         flush_done    = vt[i].fd;
         sb_q.push_back(vt[i].exp);
         step();
         e = sb_q.pop_front();
         chk($sformatf("vec%0d", i), outs(), e);
      end
      quiet();

      // threshold lowered below the current count
      epoch_thresh = 16'd100;
      for (int i = 0; i < 5; i++) begin
         access_valid = 1'b1;
         step();
      end
      chk("high_thresh_idle", busy, 1'b0);
      epoch_thresh = 16'd3;
      step();
      chk("lowered_thresh_trig", busy, 1'b1);
      run_cycles(10, p);
      chk("lowered_thresh_pulses", p, 1);

      // auto reseed disabled
      epoch_thresh = 16'd0;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         access_valid = 1'b1;
         step();
         if (busy) cnt++;
      end
      access_valid = 1'b0;
      chk("thresh0_never_busy", cnt, 0);
      sw_pulse();
      chk("sw_trig_busy", busy, 1'b1);
      run_cycles(10, p);
      chk("sw_trig_pulses", p, 1);
      chk("sw_trig_idle", busy, 1'b0);

      // misses held outstanding in DRAIN
      miss_pending = 1'b1;
      sw_pulse();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (flush_req) cnt++;
      end
      chk("drain_no_flush", cnt, 0);
      chk("drain_stall", stall_o, 1'b1);
      miss_pending = 1'b0;
      step();
      chk("drain_exit_flush", flush_req, 1'b1);
      run_cycles(5, p);
      chk("drain_pulses", p, 1);

      // requests during DRAIN and FLUSH collapse into one extra sequence
      sw_pulse();
      miss_pending = 1'b1;
      sw_pulse();
      miss_pending = 1'b0;
      step();
      chk("pend_in_flush", flush_req, 1'b1);
      sw_pulse();
      run_cycles(30, p);
      chk("pend_two_pulses", p, 2);

      // request during RESEED is absorbed
      sw_pulse();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         flush_done = flush_req;
         step();
         if (reseed) seen = 1'b1;
      end
      flush_done = 1'b0;
      chk("reach_reseed", seen, 1'b1);
      sw_pulse();
      run_cycles(20, p);
      chk("reseed_req_absorbed", p, 0);

      // auto and software trigger on the same cycle
      epoch_thresh  = 16'd1;
      access_valid  = 1'b1;
      sw_reseed_req = 1'b1;
      step();
      quiet();
      chk("simul_busy", busy, 1'b1);
      run_cycles(20, p);
      chk("simul_pulses", p, 1);

      // asynchronous reset in the middle of FLUSH
      epoch_thresh = 16'd0;
      sw_pulse();
      step();
      chk("pre_reset_flush", flush_req, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_outs", outs(), 4'b0000);
      step();
      reset      = 1'b0;
      flush_done = 1'b1;
      step();
      flush_done = 1'b0;
      chk("stray_done_ignored", outs(), 4'b0000);
      run_cycles(10, p);
      chk("stray_done_pulses", p, 0);

`ifdef RPLACE_RESEED_PERF_EN
      chk("perf_after_reset", reseed_count, 0);
      for (int i = 0; i < 3; i++) begin
         sw_pulse();
         run_cycles(8, p);
      end
      chk("perf_three", reseed_count, 3);
      chk("perf2_three", rc2, 3);
      for (int i = 0; i < 2; i++) begin
         sw_pulse();
         run_cycles(8, p);
      end
      chk("perf_five", reseed_count, 5);
      chk("perf2_wrap", rc2, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
